// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the byte-serial memory arbiter.
package mem_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StRd     = 2'b01,
        StWr     = 2'b10,
        StIoWait = 2'b11
    } arb_state_e;

    // Which port owns the transaction in flight.
    typedef enum logic {
        ReqInst = 1'b0,
        ReqData = 1'b1
    } req_id_e;

    // Load/store size codes; 2'b11 is illegal and handled as a word.
    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    // Value of the two-bit IO select field that marks an IO address.
    localparam logic [1:0] IoSel = 2'b11;

    // Number of bus bytes for a given size code.
    function automatic logic [2:0] size_to_len(input logic [1:0] size);
        case (size)
            SizeByte: size_to_len = 3'd1;
            SizeHalf: size_to_len = 3'd2;
            default:  size_to_len = 3'd4;
        endcase
    endfunction

    // Sign/zero-extend an assembled load result; words pass through.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic        sext);
        case (size)
            SizeByte: extend_load = {{24{sext & word[7]}}, word[7:0]};
            SizeHalf: extend_load = {{16{sext & word[15]}}, word[15:0]};
            default:  extend_load = word;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Byte-serial arbiter between instruction fetch and load/store on the 8-bit RAM/IO bus.
// Assembles little-endian words one byte per cycle, extends loads, stalls IO writes while
// the UART is full and freezes completely while rdy is low.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned IO_SEL_HI = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_abort,
    output logic [31:0]       inst_o,
    output logic              inst_done,
    input  logic              data_r_req,
    input  logic              data_w_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [1:0]        data_size,
    input  logic              data_sext,
    input  logic [31:0]       data_w_data,
    output logic [31:0]       data_r_data,
    output logic              data_done,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    arb_state_e        state_q, state_d;
    req_id_e           req_id_q, req_id_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [1:0]        size_q, size_d;
    logic              sext_q, sext_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic [31:0]       inst_o_q, inst_o_d;
    logic [31:0]       data_r_data_q, data_r_data_d;
    logic              inst_done_q, inst_done_d;
    logic              data_done_q, data_done_d;
    logic [7:0]        hold_q;
    logic              stalled_q;

    logic [ADDR_W-1:0] byte_addr;
    logic              is_io;
    logic [7:0]        din_eff;
    logic [1:0]        rd_lane;
    logic [1:0]        wr_lane;

    // Address of byte cnt_q; IO decode applies per byte so a wrap into IO space is caught.
    assign byte_addr = base_q + ADDR_W'(cnt_q);
    assign is_io     = (byte_addr[IO_SEL_HI -: 2] == IoSel);
    // After a pause the byte seen on the first paused cycle is used, never a re-read.
    assign din_eff   = stalled_q ? hold_q : mem_din;
    // Byte captured this edge was addressed one edge earlier.
    assign rd_lane   = cnt_q[1:0] - 2'd1;
    assign wr_lane   = cnt_q[1:0];

    // Next-state, bus sequencing and result assembly.
    always_comb begin
        state_d       = state_q;
        req_id_d      = req_id_q;
        cnt_d         = cnt_q;
        len_d         = len_q;
        base_d        = base_q;
        size_d        = size_q;
        sext_d        = sext_q;
        wdata_d       = wdata_q;
        buf_d         = buf_q;
        mem_a_d       = mem_a_q;
        mem_dout_d    = mem_dout_q;
        mem_wr_d      = 1'b0;
        inst_o_d      = inst_o_q;
        data_r_data_d = data_r_data_q;
        inst_done_d   = 1'b0;
        data_done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                mem_a_d = '0;
                cnt_d   = 3'd0;
                if (data_w_req) begin
                    state_d  = StWr;
                    req_id_d = ReqData;
                    base_d   = data_addr;
                    size_d   = data_size;
                    len_d    = size_to_len(data_size);
                    wdata_d  = data_w_data;
                end else if (data_r_req) begin
                    state_d  = StRd;
                    req_id_d = ReqData;
                    base_d   = data_addr;
                    size_d   = data_size;
                    sext_d   = data_sext;
                    len_d    = size_to_len(data_size);
                    buf_d    = '0;
                end else if (inst_req && !inst_abort) begin
                    state_d  = StRd;
                    req_id_d = ReqInst;
                    base_d   = inst_addr;
                    size_d   = SizeWord;
                    sext_d   = 1'b0;
                    len_d    = 3'd4;
                    buf_d    = '0;
                end
            end

            StRd: begin
                if (req_id_q == ReqInst && inst_abort) begin
                    state_d = StIdle;
                    mem_a_d = '0;
                    cnt_d   = 3'd0;
                end else begin
                    if (cnt_q != 3'd0) begin
                        buf_d[{rd_lane, 3'b000} +: 8] = din_eff;
                    end
                    if (cnt_q < len_q) begin
                        mem_a_d = byte_addr;
                        cnt_d   = cnt_q + 3'd1;
                    end else begin
                        state_d = StIdle;
                        mem_a_d = '0;
                        cnt_d   = 3'd0;
                        if (req_id_q == ReqInst) begin
                            inst_o_d    = buf_d;
                            inst_done_d = 1'b1;
                        end else begin
                            data_r_data_d = extend_load(buf_d, size_q, sext_q);
                            data_done_d   = 1'b1;
                        end
                    end
                end
            end

            StWr, StIoWait: begin
                mem_a_d = byte_addr;
                if (is_io && io_buffer_full) begin
                    // Hold the address with the strobe low until the UART drains.
                    state_d = StIoWait;
                end else begin
                    mem_wr_d   = 1'b1;
                    mem_dout_d = wdata_q[{wr_lane, 3'b000} +: 8];
                    if ((cnt_q + 3'd1) == len_q) begin
                        state_d     = StIdle;
                        cnt_d       = 3'd0;
                        data_done_d = 1'b1;
                    end else begin
                        state_d = StWr;
                        cnt_d   = cnt_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                mem_a_d = '0;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Main state register; every field freezes while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            req_id_q      <= ReqInst;
            cnt_q         <= 3'd0;
            len_q         <= 3'd0;
            base_q        <= '0;
            size_q        <= SizeByte;
            sext_q        <= 1'b0;
            wdata_q       <= '0;
            buf_q         <= '0;
            mem_a_q       <= '0;
            mem_dout_q    <= '0;
            mem_wr_q      <= 1'b0;
            inst_o_q      <= '0;
            data_r_data_q <= '0;
            inst_done_q   <= 1'b0;
            data_done_q   <= 1'b0;
        end else if (rdy) begin
            state_q       <= state_d;
            req_id_q      <= req_id_d;
            cnt_q         <= cnt_d;
            len_q         <= len_d;
            base_q        <= base_d;
            size_q        <= size_d;
            sext_q        <= sext_d;
            wdata_q       <= wdata_d;
            buf_q         <= buf_d;
            mem_a_q       <= mem_a_d;
            mem_dout_q    <= mem_dout_d;
            mem_wr_q      <= mem_wr_d;
            inst_o_q      <= inst_o_d;
            data_r_data_q <= data_r_data_d;
            inst_done_q   <= inst_done_d;
            data_done_q   <= data_done_d;
        end
    end

    // Pause tracking: latch mem_din on the first paused cycle only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q    <= 8'h00;
            stalled_q <= 1'b0;
        end else if (!rdy) begin
            if (!stalled_q) begin
                hold_q <= mem_din;
            end
            stalled_q <= 1'b1;
        end else begin
            stalled_q <= 1'b0;
        end
    end

    assign mem_a       = mem_a_q;
    assign mem_dout    = mem_dout_q;
    assign mem_wr      = mem_wr_q & rdy;
    assign inst_o      = inst_o_q;
    assign inst_done   = inst_done_q;
    assign data_r_data = data_r_data_q;
    assign data_done   = data_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM model on the byte bus, scoreboard queues of
// expected fetch words, load results and bus writes.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_abort;
    logic [31:0] inst_o;
    logic        inst_done;
    logic        data_r_req;
    logic        data_w_req;
    logic [31:0] data_addr;
    logic [1:0]  data_size;
    logic        data_sext;
    logic [31:0] data_w_data;
    logic [31:0] data_r_data;
    logic        data_done;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0]  ram [0:65535];
    logic        din_force;

    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_data_q[$];
    logic [39:0] exp_wr_q[$];
    logic [39:0] wr_log[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Bus read data follows the address; din_force models a bus that is no longer valid.
    assign mem_din = din_force ? 8'h5A : ram[mem_a[15:0]];

    // Record every byte the bus actually writes.
    always @(posedge clk) begin
        if (mem_wr) wr_log.push_back({mem_a, mem_dout});
    end

    mem_arbiter #(
        .ADDR_W   (32),
        .IO_SEL_HI(17)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rdy           (rdy),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_abort    (inst_abort),
        .inst_o        (inst_o),
        .inst_done     (inst_done),
        .data_r_req    (data_r_req),
        .data_w_req    (data_w_req),
        .data_addr     (data_addr),
        .data_size     (data_size),
        .data_sext     (data_sext),
        .data_w_data   (data_w_data),
        .data_r_data   (data_r_data),
        .data_done     (data_done),
        .mem_din       (mem_din),
        .mem_dout      (mem_dout),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a: got %h expected %h", mem_a, 32'h0); end
        n_checks++; if (mem_dout !== 8'h0) begin n_fail++; $display("FAIL reset_mem_dout: got %h expected %h", mem_dout, 8'h0); end
        n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %b expected 0", mem_wr); end
        n_checks++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst_o: got %h expected %h", inst_o, 32'h0); end
        n_checks++; if (data_r_data !== 32'h0) begin n_fail++; $display("FAIL reset_data_r_data: got %h expected %h", data_r_data, 32'h0); end
        n_checks++; if ({inst_done, data_done} !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b expected 00", {inst_done, data_done}); end
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        n_checks++; if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL idle_bus: got a=%h wr=%b expected a=0 wr=0", mem_a, mem_wr); end
    endtask

    task automatic test_fetch();
        int          done_at;
        logic [31:0] e;
        exp_inst_q.push_back(32'h10111213);
        inst_addr = 32'h0000_1000;
        inst_req  = 1'b1;
        done_at   = -1;
        for (int k = 0; k < 15; k++) begin
            step();
            if (k >= 1 && k <= 4) begin
                n_checks++;
                if (mem_a !== 32'h1000 + 32'(k - 1)) begin n_fail++; $display("FAIL fetch_addr%0d: got %h expected %h", k, mem_a, 32'h1000 + 32'(k - 1)); end
            end
            if (inst_done) begin
                done_at  = k;
                inst_req = 1'b0;
                e = exp_inst_q.pop_front();
                n_checks++; if (inst_o !== e) begin n_fail++; $display("FAIL fetch_word: got %h expected %h", inst_o, e); end
                break;
            end
        end
        inst_req = 1'b0;
        n_checks++; if (done_at != 5) begin n_fail++; $display("FAIL fetch_latency: got %0d expected 5", done_at); end
        step();
        n_checks++; if (inst_done !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse: got %b expected 0", inst_done); end
    endtask

    task automatic test_priority();
        int          data_at;
        int          inst_at;
        logic [31:0] e;
        exp_data_q.push_back(32'hFFFF_FF80);
        exp_inst_q.push_back(32'h10111213);
        data_addr  = 32'h20;
        data_size  = 2'b00;
        data_sext  = 1'b1;
        data_r_req = 1'b1;
        inst_addr  = 32'h1000;
        inst_req   = 1'b1;
        data_at    = -1;
        inst_at    = -1;
        for (int k = 0; k < 20; k++) begin
            step();
            n_checks++; if (inst_done && data_done) begin n_fail++; $display("FAIL both_done: got 11 expected not both"); end
            if (data_done) begin
                data_at    = k;
                data_r_req = 1'b0;
                e = exp_data_q.pop_front();
                n_checks++; if (data_r_data !== e) begin n_fail++; $display("FAIL lb_sext: got %h expected %h", data_r_data, e); end
            end
            if (inst_done) begin
                inst_at  = k;
                inst_req = 1'b0;
                e = exp_inst_q.pop_front();
                n_checks++; if (inst_o !== e) begin n_fail++; $display("FAIL prio_fetch_word: got %h expected %h", inst_o, e); end
                break;
            end
        end
        data_r_req = 1'b0;
        inst_req   = 1'b0;
        n_checks++; if (data_at != 2) begin n_fail++; $display("FAIL prio_data_latency: got %0d expected 2", data_at); end
        n_checks++; if (inst_at != 8) begin n_fail++; $display("FAIL prio_inst_latency: got %0d expected 8", inst_at); end
        step();
    endtask

    task automatic test_store_half();
        int          done_at;
        int          hi;
        logic [39:0] e;
        logic [39:0] g;
        wr_log.delete();
        exp_wr_q.push_back({32'h100, 8'h34});
        exp_wr_q.push_back({32'h101, 8'h12});
        data_addr   = 32'h100;
        data_size   = 2'b01;
        data_w_data = 32'hABCD_1234;
        data_w_req  = 1'b1;
        done_at     = -1;
        hi          = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (mem_wr) hi++;
            if (data_done && done_at < 0) begin
                done_at    = k;
                data_w_req = 1'b0;
            end
            if (done_at >= 0 && k >= done_at + 3) break;
        end
        data_w_req = 1'b0;
        n_checks++; if (done_at != 2) begin n_fail++; $display("FAIL sh_done_latency: got %0d expected 2", done_at); end
        n_checks++; if (hi != 2) begin n_fail++; $display("FAIL sh_wr_cycles: got %0d expected 2", hi); end
        while (exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            g = (wr_log.size() > 0) ? wr_log.pop_front() : 40'hxx;
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL sh_write: got %h expected %h", g, e); end
        end
        n_checks++; if (wr_log.size() != 0) begin n_fail++; $display("FAIL sh_extra_writes: got %0d expected 0", wr_log.size()); end
    endtask

    task automatic test_io_stall();
        logic [39:0] e;
        logic [39:0] g;
        wr_log.delete();
        exp_wr_q.push_back({32'h0003_0000, 8'h41});
        io_buffer_full = 1'b1;
        data_addr      = 32'h0003_0000;
        data_size      = 2'b00;
        data_w_data    = 32'h0000_0041;
        data_w_req     = 1'b1;
        step();
        for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL io_stall_wr%0d: got %b expected 0", i, mem_wr); end
            n_checks++; if (mem_a !== 32'h0003_0000) begin n_fail++; $display("FAIL io_stall_addr%0d: got %h expected %h", i, mem_a, 32'h0003_0000); end
        end
        io_buffer_full = 1'b0;
        step();
        n_checks++; if (mem_wr !== 1'b1 || data_done !== 1'b1) begin n_fail++; $display("FAIL io_issue: got wr=%b done=%b expected 1 1", mem_wr, data_done); end
        data_w_req = 1'b0;
        step();
        step();
        while (exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            g = (wr_log.size() > 0) ? wr_log.pop_front() : 40'hxx;
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL io_write: got %h expected %h", g, e); end
        end
        n_checks++; if (wr_log.size() != 0) begin n_fail++; $display("FAIL io_extra_writes: got %0d expected 0", wr_log.size()); end
    endtask

    task automatic test_abort();
        int          done_at;
        logic [31:0] e;
        exp_inst_q.push_back(32'h4433_2211);
        inst_addr = 32'h1000;
        inst_req  = 1'b1;
        for (int k = 0; k < 4; k++) step();
        n_checks++; if (mem_a !== 32'h1002) begin n_fail++; $display("FAIL abort_third_byte: got %h expected %h", mem_a, 32'h1002); end
        inst_abort = 1'b1;
        inst_addr  = 32'h1004;
        step();
        inst_abort = 1'b0;
        n_checks++; if (mem_a !== 32'h0 || inst_done !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got a=%h done=%b expected a=0 done=0", mem_a, inst_done); end
        done_at = -1;
        for (int k = 1; k < 16; k++) begin
            step();
            if (inst_done) begin
                done_at  = k;
                inst_req = 1'b0;
                e = exp_inst_q.pop_front();
                n_checks++; if (inst_o !== e) begin n_fail++; $display("FAIL abort_refetch_word: got %h expected %h", inst_o, e); end
                break;
            end
        end
        inst_req = 1'b0;
        n_checks++; if (done_at != 6) begin n_fail++; $display("FAIL abort_refetch_latency: got %0d expected 6", done_at); end
        step();
    endtask

    task automatic test_idle_abort();
        int          done_at;
        logic [31:0] e;
        exp_inst_q.push_back(32'h4433_2211);
        inst_addr  = 32'h1004;
        inst_req   = 1'b1;
        inst_abort = 1'b1;
        step();
        inst_abort = 1'b0;
        step();
        n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL idle_abort_suppress: got %h expected %h", mem_a, 32'h0); end
        step();
        n_checks++; if (mem_a !== 32'h1004) begin n_fail++; $display("FAIL idle_abort_late_accept: got %h expected %h", mem_a, 32'h1004); end
        done_at = -1;
        for (int k = 3; k < 16; k++) begin
            step();
            if (inst_done) begin
                done_at  = k;
                inst_req = 1'b0;
                e = exp_inst_q.pop_front();
                n_checks++; if (inst_o !== e) begin n_fail++; $display("FAIL idle_abort_word: got %h expected %h", inst_o, e); end
                break;
            end
        end
        inst_req = 1'b0;
        n_checks++; if (done_at != 6) begin n_fail++; $display("FAIL idle_abort_latency: got %0d expected 6", done_at); end
        step();
    endtask

    task automatic test_rdy_read();
        int          done_at;
        logic [31:0] e;
        exp_data_q.push_back(32'hEFBE_ADDE);
        data_addr  = 32'h200;
        data_size  = 2'b10;
        data_sext  = 1'b0;
        data_r_req = 1'b1;
        step();
        step();
        step();
        n_checks++; if (mem_a !== 32'h201) begin n_fail++; $display("FAIL rdy_pre_addr: got %h expected %h", mem_a, 32'h201); end
        rdy = 1'b0;
        step();
        din_force = 1'b1;
        step();
        step();
        step();
        n_checks++; if (mem_a !== 32'h201) begin n_fail++; $display("FAIL rdy_frozen_addr: got %h expected %h", mem_a, 32'h201); end
        rdy = 1'b1;
        step();
        din_force = 1'b0;
        done_at   = -1;
        for (int k = 8; k < 20; k++) begin
            step();
            if (data_done) begin
                done_at    = k;
                data_r_req = 1'b0;
                e = exp_data_q.pop_front();
                n_checks++; if (data_r_data !== e) begin n_fail++; $display("FAIL rdy_lw_word: got %h expected %h", data_r_data, e); end
                break;
            end
        end
        data_r_req = 1'b0;
        n_checks++; if (done_at != 9) begin n_fail++; $display("FAIL rdy_lw_latency: got %0d expected 9", done_at); end
        step();
    endtask

    task automatic test_rdy_write();
        logic [39:0] e;
        logic [39:0] g;
        int          done_at;
        wr_log.delete();
        exp_wr_q.push_back({32'h400, 8'h44});
        exp_wr_q.push_back({32'h401, 8'h33});
        exp_wr_q.push_back({32'h402, 8'h22});
        exp_wr_q.push_back({32'h403, 8'h11});
        data_addr   = 32'h400;
        data_size   = 2'b10;
        data_w_data = 32'h1122_3344;
        data_w_req  = 1'b1;
        step();
        step();
        rdy = 1'b0;
        #1;
        n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL rdy_gate_wr: got %b expected 0", mem_wr); end
        step();
        step();
        step();
        rdy = 1'b1;
        #1;
        n_checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h400) begin n_fail++; $display("FAIL rdy_resume_wr: got wr=%b a=%h expected wr=1 a=400", mem_wr, mem_a); end
        done_at = -1;
        for (int k = 0; k < 15; k++) begin
            step();
            if (data_done) begin
                done_at    = k;
                data_w_req = 1'b0;
                break;
            end
        end
        data_w_req = 1'b0;
        n_checks++; if (done_at < 0) begin n_fail++; $display("FAIL rdy_sw_done: got timeout expected data_done"); end
        step();
        step();
        while (exp_wr_q.size() > 0) begin
            e = exp_wr_q.pop_front();
            g = (wr_log.size() > 0) ? wr_log.pop_front() : 40'hxx;
            n_checks++; if (g !== e) begin n_fail++; $display("FAIL rdy_sw_write: got %h expected %h", g, e); end
        end
        n_checks++; if (wr_log.size() != 0) begin n_fail++; $display("FAIL rdy_sw_duplicate: got %0d extra expected 0", wr_log.size()); end
    endtask

    task automatic test_reset_mid_write();
        logic [39:0] g;
        int          done_at;
        logic [31:0] e;
        wr_log.delete();
        data_addr   = 32'h500;
        data_size   = 2'b10;
        data_w_data = 32'hCAFE_F00D;
        data_w_req  = 1'b1;
        step();
        step();
        step();
        #3 rst = 1'b0;
        #1;
        data_w_req = 1'b0;
        n_checks++; if (mem_a !== 32'h0 || mem_dout !== 8'h0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL async_rst_bus: got a=%h d=%h wr=%b expected 0 0 0", mem_a, mem_dout, mem_wr); end
        n_checks++; if (inst_o !== 32'h0 || data_r_data !== 32'h0) begin n_fail++; $display("FAIL async_rst_results: got %h %h expected 0 0", inst_o, data_r_data); end
        n_checks++; if ({inst_done, data_done} !== 2'b00) begin n_fail++; $display("FAIL async_rst_done: got %b expected 00", {inst_done, data_done}); end
        @(posedge clk);
        #1 rst = 1'b1;
        step();
        n_checks++; if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle: got a=%h wr=%b expected 0 0", mem_a, mem_wr); end
        g = (wr_log.size() > 0) ? wr_log.pop_front() : 40'hxx;
        n_checks++; if (g !== {32'h500, 8'h0D}) begin n_fail++; $display("FAIL pre_rst_write: got %h expected %h", g, {32'h500, 8'h0D}); end
        n_checks++; if (wr_log.size() != 0) begin n_fail++; $display("FAIL post_rst_writes: got %0d expected 0", wr_log.size()); end
        exp_inst_q.push_back(32'h4433_2211);
        inst_addr = 32'h1004;
        inst_req  = 1'b1;
        done_at   = -1;
        for (int k = 0; k < 15; k++) begin
            step();
            if (inst_done) begin
                done_at  = k;
                inst_req = 1'b0;
                e = exp_inst_q.pop_front();
                n_checks++; if (inst_o !== e) begin n_fail++; $display("FAIL post_rst_fetch: got %h expected %h", inst_o, e); end
                break;
            end
        end
        inst_req = 1'b0;
        n_checks++; if (done_at != 5) begin n_fail++; $display("FAIL post_rst_latency: got %0d expected 5", done_at); end
        step();
    endtask

    // Bound the run in case the design wedges.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h1000] = 8'h13; ram[16'h1001] = 8'h12; ram[16'h1002] = 8'h11; ram[16'h1003] = 8'h10;
        ram[16'h1004] = 8'h11; ram[16'h1005] = 8'h22; ram[16'h1006] = 8'h33; ram[16'h1007] = 8'h44;
        ram[16'h0020] = 8'h80;
        ram[16'h0200] = 8'hDE; ram[16'h0201] = 8'hAD; ram[16'h0202] = 8'hBE; ram[16'h0203] = 8'hEF;
        din_force      = 1'b0;
        rdy            = 1'b1;
        inst_req       = 1'b0;
        inst_addr      = 32'h0;
        inst_abort     = 1'b0;
        data_r_req     = 1'b0;
        data_w_req     = 1'b0;
        data_addr      = 32'h0;
        data_size      = 2'b00;
        data_sext      = 1'b0;
        data_w_data    = 32'h0;
        io_buffer_full = 1'b0;

        test_reset();
        test_fetch();
        test_priority();
        test_store_half();
        test_io_stall();
        test_abort();
        test_idle_abort();
        test_rdy_read();
        test_rdy_write();
        test_reset_mid_write();

        n_checks++;
        if (exp_inst_q.size() + exp_data_q.size() + exp_wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0",
                     exp_inst_q.size() + exp_data_q.size() + exp_wr_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Byte-serial memory arbiter between the instruction-fetch port and the data (load/store) port on the CPU's single 8-bit RAM/IO bus. It sequences multi-byte transfers as one byte per cycle, assembles little-endian words, and sign/zero-extends loads. It stalls IO writes while the UART is full and honours global pause (rdy). It sits between the IF/MEM pipeline stages and the top-level mem_a/mem_din/mem_dout/mem_wr pins.

Parameters:
ADDR_W, 32, address width on all ports
IO_SEL_HI, 17, upper bit of IO select field; address is IO when addr[17:16]==2'b11

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; low freezes block
inst_req  in  1  fetch request (level, held until inst_done or abort)
inst_addr  in  32  fetch address
inst_abort  in  1  branch flush; cancels in-flight fetch
inst_o  out  32  fetched word
inst_done  out  1  one-cycle pulse, inst_o valid
data_r_req  in  1  load request (level)
data_w_req  in  1  store request (level)
data_addr  in  32  load/store address
data_size  in  2  00 byte, 01 half, 10 word (11 illegal, treated as word)
data_sext  in  1  1 = sign-extend load result
data_w_data  in  32  store data, byte0 = [7:0]
data_r_data  out  32  extended load result
data_done  out  1  one-cycle pulse, load/store complete
mem_din  in  8  RAM/IO read byte (valid cycle after address)
mem_dout  out  8  write byte
mem_a  out  32  bus address
mem_wr  out  1  1 = write
io_buffer_full  in  1  UART tx buffer full

Behaviour:
- Reset (rst low, async): state IDLE, byte counter 0, mem_a=0, mem_dout=0, mem_wr=0, inst_o=0, data_r_data=0, inst_done=0, data_done=0.
- States: IDLE, RD (read byte issue/capture), WR (write byte issue), IO_WAIT.
- IDLE arbitration, non-preemptive, sampled at each edge: data_w_req > data_r_req > inst_req (older instruction first). In IDLE, mem_a=0 and mem_wr=0, so the idle bus never touches IO.
- Byte count N = 1/2/4 from data_size; fetch is always N=4. Byte k uses address base+k, 32-bit wrap.
- Read: request accepted at edge E0. Addresses base+0..N-1 driven in the cycles after edges E1..EN. Byte k is captured from mem_din at edge E(k+2). At edge E(N+1), state returns to IDLE and done pulses high for that one cycle with result valid. Word fetch: accept E0, inst_done high after E5.
- Write: bytes driven with mem_wr=1 in the cycles after E1..EN. data_done pulses after EN, and state returns to IDLE.
- Completed transaction to next accept: one IDLE cycle minimum.
- IO write (IO address, mem_wr would be 1) while io_buffer_full=1: enter IO_WAIT with mem_wr=0 and the address held. Issue on the first edge where io_buffer_full=0.
- Load extension: byte/half results are extended per data_sext from bit 7/15. Word results are unmodified.
- inst_abort while state RD serving fetch: return to IDLE at next edge, no inst_done, partial data discarded. inst_abort in IDLE: suppresses acceptance of inst_req that edge. Data transactions are never aborted.
- rdy low: all registers frozen and mem_wr output gated to 0. On the first rdy-low cycle, mem_din is captured into a hold register. The pending byte in the first resumed cycle is taken from the hold register, so IO reads are never re-issued.
- inst_done and data_done are never both high in one cycle.

Decomposition:
- Shared package mem_arb_pkg holds: state encoding (IDLE/RD/WR/IO_WAIT), data_size codes, IO select constant 2'b11, and a requester-ID encoding (INST/DATA).
- No sub-module; the byte assembly/extension logic stays inline.

Test Plan:
- Word fetch at 0x0000_1000, RAM bytes 13,12,11,10 → inst_o=0x10111213, inst_done single pulse 5 cycles after accept; mem_a steps 0x1000..0x1003.
- inst_req and data_r_req (lb, sext, addr 0x20, byte 0x80) asserted same edge → data served first, data_r_data=0xFFFFFF80; fetch starts after one IDLE cycle.
- sh 0xABCD1234 to 0x100 → mem_wr=1 for exactly two cycles, bytes 0x34@0x100 then 0x12@0x101, data_done after 2nd.
- sb 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles → mem_wr stays 0 for those cycles, then one write of 0x41 to 0x30000.
- inst_abort on third byte of a fetch → no inst_done, IDLE next edge, next fetch returns correct word.
- rdy low for 4 cycles mid lw, plus async rst asserted mid-write → correct word after resume with no duplicate mem_wr; after reset all outputs are 0 immediately.
